// File: rtl/sisc_pkg.sv
// Shared types and constants for the SISC memory access scheduler.
package sisc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;
    localparam int LAT_W       = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/mem_sched_pick.sv
// Combinational grant selection between fetch and data requesters.
// With MEM_SCHED_RR_EN defined, simultaneous requests alternate via a pointer.
module mem_sched_pick
    import sisc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic dm_req,
    input  logic take,
    output logic gnt_valid,
    output logic gnt_id
);

    assign gnt_valid = if_req | dm_req;

`ifdef MEM_SCHED_RR_EN
    logic ptr;

    // Pointer names the winner of the next conflict; it moves away from whoever was just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= REQ_DM;
        end else if (take) begin
            ptr <= ~gnt_id;
        end
    end

    always_comb begin
        gnt_id = REQ_DM;
        if (if_req && dm_req) begin
            gnt_id = ptr;
        end else if (if_req) begin
            gnt_id = REQ_IF;
        end
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clk, rst, take};

    always_comb begin
        gnt_id = REQ_DM;
        if (if_req && !dm_req) begin
            gnt_id = REQ_IF;
        end
    end
`endif

endmodule

// File: rtl/mem_sched.sv
// Shares one fixed-latency single-ported memory between instruction fetch and load/store.
// Optional build macro: MEM_SCHED_RR_EN (round-robin on simultaneous requests).
module mem_sched
    import sisc_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_data,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [7:0]        stall_cnt
);

    // Out-of-range latencies are pinned to the nearest legal value.
    localparam int LAT = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                         (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;

    state_t           state;
    state_t           state_next;
    logic             gnt_valid;
    logic             gnt_id;
    logic             take;
    logic             req_id;
    logic             req_we;
    logic [LAT_W-1:0] lat_cnt;
    logic             lat_done;

    assign take     = (state == IDLE) && gnt_valid;
    assign lat_done = (state == WAIT) && (lat_cnt == LAT_W'(1));

    mem_sched_pick u_pick (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .dm_req    (dm_req),
        .take      (take),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (gnt_valid) state_next = ISSUE;
            ISSUE:   state_next = req_we ? DONE : WAIT;
            WAIT:    if (lat_done) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign mem_en = (state == ISSUE);
    assign mem_we = (state == ISSUE) && req_we;
    assign if_ack = (state == DONE) && (req_id == REQ_IF);
    assign dm_ack = (state == DONE) && (req_id == REQ_DM);
    assign busy   = (state != IDLE);

    // Request fields are latched at grant so the requester may change them once acked.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_id    <= REQ_IF;
            req_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (take) begin
            req_id   <= gnt_id;
            req_we   <= (gnt_id == REQ_DM) && dm_we;
            mem_addr <= (gnt_id == REQ_DM) ? dm_addr : if_addr;
            if ((gnt_id == REQ_DM) && dm_we) begin
                mem_wdata <= dm_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt  <= '0;
            if_data  <= '0;
            dm_rdata <= '0;
        end else begin
            if (state == ISSUE) begin
                lat_cnt <= LAT_W'(LAT);
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            if (lat_done) begin
                if (req_id == REQ_IF) begin
                    if_data <= mem_rdata;
                end else begin
                    dm_rdata <= mem_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (if_req && !if_ack && (stall_cnt != 8'hFF)) begin
            stall_cnt <= stall_cnt + 8'd1;
        end
    end

endmodule
